uart_receiver: RTL and testbench

Serial-to-parallel UART receive datapath with an embedded control FSM. It recovers frames from the asynchronous rx line using 16x oversampling and checks parity and stop bits. Each accepted byte is pushed into the receive FIFO through a single-cycle write strobe. It sits between the rx pad and the rx FIFO, and is configured by the same control fields as the UART transmit side: uart_en, rx_en, parity_enable, stop_bit.

---
 rtl/uart_receiver.sv | 267 ++++++++++++++++++++++++++
 tb/tb_uart_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver
// Serial-to-parallel UART receive path with 16x oversampling. Frames on
// rx_serial are synchronised, sampled at bit centre, checked for parity and
// stop errors, and each completed frame is offered to the rx FIFO through a
// one-cycle write strobe.
//
// Ports
//   clock, reset      system clock, asynchronous active-high reset
//   uart_en, rx_en    both must be high for reception; dropping either aborts
//   baud_div          clocks per oversample tick minus 1 (latched per frame)
//   parity_enable     a parity bit follows the data bits
//   parity_odd        1 = odd parity, 0 = even parity
//   stop_bit          0 = one stop bit, 1 = two stop bits
//   rx_serial         asynchronous serial input, idles high
//   rx_fifo_full      FIFO cannot accept a write
//   rx_fifo_wr_en     one-cycle write strobe
//   rx_data           last byte written
//   parity_error, stop_bit_error, overrun_error  status of last completed frame
//   busy              a frame is in progress
module uart_receiver #(
   parameter int DATA_WIDTH = 8,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  uart_en,
   input  logic                  rx_en,
   input  logic [DIV_WIDTH-1:0]  baud_div,
   input  logic                  parity_enable,
   input  logic                  parity_odd,
   input  logic                  stop_bit,
   input  logic                  rx_serial,
   input  logic                  rx_fifo_full,
   output logic                  rx_fifo_wr_en,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  parity_error,
   output logic                  stop_bit_error,
   output logic                  overrun_error,
   output logic                  busy
);

   localparam int BCW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Parity bit a transmitter would have sent for this data word.
   function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] data,
                                            input logic                  odd);
      expected_parity = (^data) ^ odd;
   endfunction

   state_t                 state_q, state_d;
   logic                   sync1_q, sync2_q;
   logic                   armed_q, armed_d;
   logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
   logic [DIV_WIDTH-1:0]   baud_q, baud_d;
   logic [3:0]             tick_cnt_q, tick_cnt_d;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]  shift_q, shift_d;
   logic                   par_err_q, par_err_d;
   logic                   stop_err_q, stop_err_d;
   logic                   second_stop_q, second_stop_d;
   logic                   wr_en_q, wr_en_d;
   logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
   logic                   parity_error_q, parity_error_d;
   logic                   stop_bit_error_q, stop_bit_error_d;
   logic                   overrun_error_q, overrun_error_d;
   logic                   busy_q, busy_d;

   logic                   rx_sync_s;
   logic                   enable_s;
   logic                   tick_s;
   logic                   sample_s;

   assign rx_sync_s = sync2_q;
   assign enable_s  = uart_en & rx_en;
   assign tick_s    = (state_q != ST_IDLE) && (div_cnt_q == {DIV_WIDTH{1'b0}});
   // Start bit is sampled at its centre (8th tick); later bits after 16 ticks.
   assign sample_s  = tick_s && ((state_q == ST_START) ? (tick_cnt_q == 4'd7)
                                                       : (tick_cnt_q == 4'd15));

   assign rx_fifo_wr_en  = wr_en_q;
   assign rx_data        = rx_data_q;
   assign parity_error   = parity_error_q;
   assign stop_bit_error = stop_bit_error_q;
   assign overrun_error  = overrun_error_q;
   assign busy           = busy_q;

   // Two-flop synchroniser for the asynchronous serial line.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_serial;
         sync2_q <= sync1_q;
      end
   end

   // Next-state, datapath and output computation.
   always_comb begin
      state_d          = state_q;
      div_cnt_d        = div_cnt_q;
      baud_d           = baud_q;
      tick_cnt_d       = tick_cnt_q;
      bit_cnt_d        = bit_cnt_q;
      shift_d          = shift_q;
      par_err_d        = par_err_q;
      stop_err_d       = stop_err_q;
      second_stop_d    = second_stop_q;
      wr_en_d          = 1'b0;
      rx_data_d        = rx_data_q;
      parity_error_d   = parity_error_q;
      stop_bit_error_d = stop_bit_error_q;
      overrun_error_d  = overrun_error_q;

      // A start is only accepted once the line has been seen high in IDLE,
      // so a held-low line (break) produces a single frame.
      if (rx_sync_s) begin
         armed_d = 1'b1;
      end else if (state_q != ST_IDLE) begin
         armed_d = 1'b0;
      end else begin
         armed_d = armed_q;
      end

      if (state_q != ST_IDLE) begin
         if (tick_s) begin
            div_cnt_d  = baud_q;
            tick_cnt_d = tick_cnt_q + 4'd1;
         end else begin
            div_cnt_d  = div_cnt_q - {{(DIV_WIDTH-1){1'b0}}, 1'b1};
         end
      end else begin
         div_cnt_d = div_cnt_q;
      end

      if ((state_q != ST_IDLE) && !enable_s) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable_s && !rx_sync_s && armed_q) begin
                  state_d       = ST_START;
                  armed_d       = 1'b0;
                  baud_d        = baud_div;
                  div_cnt_d     = baud_div;
                  tick_cnt_d    = 4'd0;
                  bit_cnt_d     = {BCW{1'b0}};
                  par_err_d     = 1'b0;
                  stop_err_d    = 1'b0;
                  second_stop_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_START: begin
               if (sample_s) begin
                  if (rx_sync_s) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d    = ST_DATA;
                     tick_cnt_d = 4'd0;
                  end
               end else begin
                  state_d = ST_START;
               end
            end
            ST_DATA: begin
               if (sample_s) begin
                  shift_d   = {rx_sync_s, shift_q[DATA_WIDTH-1:1]};
                  bit_cnt_d = bit_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
                  if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                     state_d = parity_enable ? ST_PARITY : ST_STOP;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end
            ST_PARITY: begin
               if (sample_s) begin
                  par_err_d = rx_sync_s ^ expected_parity(shift_q, parity_odd);
                  state_d   = ST_STOP;
               end else begin
                  state_d = ST_PARITY;
               end
            end
            ST_STOP: begin
               if (sample_s) begin
                  stop_err_d = stop_err_q | ~rx_sync_s;
                  if (stop_bit && !second_stop_q) begin
                     second_stop_d = 1'b1;
                     state_d       = ST_STOP;
                  end else begin
                     // Frame complete: all status flags move together.
                     state_d          = ST_IDLE;
                     parity_error_d   = par_err_q;
                     stop_bit_error_d = stop_err_q | ~rx_sync_s;
                     if (!rx_fifo_full) begin
                        wr_en_d         = 1'b1;
                        rx_data_d       = shift_q;
                        overrun_error_d = 1'b0;
                     end else begin
                        overrun_error_d = 1'b1;
                     end
                  end
               end else begin
                  state_d = ST_STOP;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         armed_q          <= 1'b0;
         div_cnt_q        <= {DIV_WIDTH{1'b0}};
         baud_q           <= {DIV_WIDTH{1'b0}};
         tick_cnt_q       <= 4'd0;
         bit_cnt_q        <= {BCW{1'b0}};
         shift_q          <= {DATA_WIDTH{1'b0}};
         par_err_q        <= 1'b0;
         stop_err_q       <= 1'b0;
         second_stop_q    <= 1'b0;
         wr_en_q          <= 1'b0;
         rx_data_q        <= {DATA_WIDTH{1'b0}};
         parity_error_q   <= 1'b0;
         stop_bit_error_q <= 1'b0;
         overrun_error_q  <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         armed_q          <= armed_d;
         div_cnt_q        <= div_cnt_d;
         baud_q           <= baud_d;
         tick_cnt_q       <= tick_cnt_d;
         bit_cnt_q        <= bit_cnt_d;
         shift_q          <= shift_d;
         par_err_q        <= par_err_d;
         stop_err_q       <= stop_err_d;
         second_stop_q    <= second_stop_d;
         wr_en_q          <= wr_en_d;
         rx_data_q        <= rx_data_d;
         parity_error_q   <= parity_error_d;
         stop_bit_error_q <= stop_bit_error_d;
         overrun_error_q  <= overrun_error_d;
         busy_q           <= busy_d;
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: a serial-line driver pushes the expected result
// of every frame into a queue; a monitor compares on each FIFO write strobe.
module tb_uart_receiver;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        uart_en = 1'b1;
   logic        rx_en = 1'b1;
   logic [15:0] baud_div = 16'd0;
   logic        parity_enable = 1'b0;
   logic        parity_odd = 1'b0;
   logic        stop_bit = 1'b0;
   logic        rx_serial = 1'b1;
   logic        rx_fifo_full = 1'b0;
   logic        rx_fifo_wr_en;
   logic [7:0]  rx_data;
   logic        parity_error;
   logic        stop_bit_error;
   logic        overrun_error;
   logic        busy;

   uart_receiver #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
      .clock          (clock),
      .reset          (reset),
      .uart_en        (uart_en),
      .rx_en          (rx_en),
      .baud_div       (baud_div),
      .parity_enable  (parity_enable),
      .parity_odd     (parity_odd),
      .stop_bit       (stop_bit),
      .rx_serial      (rx_serial),
      .rx_fifo_full   (rx_fifo_full),
      .rx_fifo_wr_en  (rx_fifo_wr_en),
      .rx_data        (rx_data),
      .parity_error   (parity_error),
      .stop_bit_error (stop_bit_error),
      .overrun_error  (overrun_error),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       serr;
   } exp_t;

   exp_t       exp_q[$];
   int         chk_cnt = 0;
   int         pass_cnt = 0;
   int         cyc = 0;
   int         lat_start = -1;
   int         exp_writes = 0;
   int         seen_writes = 0;
   logic [7:0] m_data = 8'h00;
   logic       m_perr = 1'b0;
   logic       m_serr = 1'b0;
   logic       m_ovr = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every write strobe must match the oldest outstanding frame.
   always @(negedge clock) begin : monitor
      exp_t e;
      if (rx_fifo_wr_en === 1'b1) begin
         seen_writes++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", {24'd0, rx_data}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("wr_data", {24'd0, rx_data}, {24'd0, e.data});
            check("wr_parity_error", {31'd0, parity_error}, {31'd0, e.perr});
            check("wr_stop_error", {31'd0, stop_bit_error}, {31'd0, e.serr});
            check("wr_overrun", {31'd0, overrun_error}, 32'd0);
         end
         if (lat_start >= 0) begin
            check("latency_in_range", {31'd0, ((cyc - lat_start) >= 154) && ((cyc - lat_start) <= 156)}, 32'd1);
            lat_start = -1;
         end
      end
   end

   task automatic drive_bit(input logic v, input int n);
      rx_serial = v;
      repeat (n) @(negedge clock);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, m_data});
      check({tag, "_parity_error"}, {31'd0, parity_error}, {31'd0, m_perr});
      check({tag, "_stop_error"}, {31'd0, stop_bit_error}, {31'd0, m_serr});
      check({tag, "_overrun"}, {31'd0, overrun_error}, {31'd0, m_ovr});
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   // Send one frame; flip_par corrupts the parity bit, stop_lvl gives the stop levels.
   task automatic send_frame(input logic [7:0] data, input logic pen, input logic podd,
                             input logic two, input logic flip_par, input logic [1:0] stop_lvl,
                             input logic full, input int bdiv, input logic lat);
      int   bc;
      int   ones;
      logic pbit;
      logic perr;
      logic serr;
      exp_t e;
      bc = 16 * (bdiv + 1);
      @(negedge clock);
      baud_div = 16'(bdiv);
      parity_enable = pen;
      parity_odd = podd;
      stop_bit = two;
      rx_fifo_full = full;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(data[i]);
      // Correct parity bit makes the total count of ones even (or odd).
      pbit = ((ones % 2) != 0) ^ podd ^ flip_par;
      perr = pen && (((ones + int'(pbit)) % 2) != int'(podd));
      serr = !stop_lvl[0] || (two && !stop_lvl[1]);
      if (!full) begin
         e.data = data; e.perr = perr; e.serr = serr;
         exp_q.push_back(e);
         exp_writes++;
         m_data = data;
         m_ovr = 1'b0;
      end else begin
         m_ovr = 1'b1;
      end
      m_perr = perr;
      m_serr = serr;
      if (lat) lat_start = cyc;
      drive_bit(1'b0, bc);
      for (int i = 0; i < 8; i++) drive_bit(data[i], bc);
      if (pen) drive_bit(pbit, bc);
      drive_bit(stop_lvl[0], bc);
      if (two) drive_bit(stop_lvl[1], bc);
      drive_bit(1'b1, 2 * bc);
      check_status("frame");
      rx_fifo_full = 1'b0;
   endtask

   // Start a frame, then abort after 4 data bits with reset (mode 0) or rx_en (mode 1).
   task automatic abort_frame(input logic [7:0] data, input int mode);
      int bc;
      bc = 16;
      @(negedge clock);
      baud_div = 16'd0;
      parity_enable = 1'b0;
      stop_bit = 1'b0;
      drive_bit(1'b0, bc);
      for (int i = 0; i < 4; i++) drive_bit(data[i], bc);
      check("abort_busy_before", {31'd0, busy}, 32'd1);
      rx_serial = 1'b1;
      if (mode == 0) begin
         reset = 1'b1;
         @(negedge clock);
         reset = 1'b0;
         m_data = 8'h00; m_perr = 1'b0; m_serr = 1'b0; m_ovr = 1'b0;
      end else begin
         rx_en = 1'b0;
         @(negedge clock);
      end
      check("abort_busy_after", {31'd0, busy}, 32'd0);
      repeat (2 * bc) @(negedge clock);
      rx_en = 1'b1;
      check_status("abort");
   endtask

   initial begin
      int bdv;
      repeat (3) @(negedge clock);
      check("reset_wr_en", {31'd0, rx_fifo_wr_en}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_flags", {29'd0, parity_error, stop_bit_error, overrun_error}, 32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clock);

      // Plain frame, with latency measurement.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, 1'b1);
      // Even parity: wrong bit, then correct bit.
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 0, 1'b0);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, 1'b0);
      // Two stop bits, second one low.
      send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 0, 1'b0);
      // Overrun, then recovery.
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 0, 1'b0);
      send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, 1'b0);

      // Short glitch is a false start: busy briefly, no write, flags kept.
      @(negedge clock);
      baud_div = 16'd3;
      drive_bit(1'b0, 3);
      drive_bit(1'b1, 2);
      check("glitch_busy", {31'd0, busy}, 32'd1);
      repeat (60) @(negedge clock);
      check_status("glitch");

      abort_frame(8'hC3, 0);
      abort_frame(8'h3C, 1);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 0, 1'b0);

      // Break: line low well beyond one frame gives a single zero frame.
      @(negedge clock);
      baud_div = 16'd0;
      parity_enable = 1'b0;
      stop_bit = 1'b0;
      exp_q.push_back('{data: 8'h00, perr: 1'b0, serr: 1'b1});
      exp_writes++;
      m_data = 8'h00; m_perr = 1'b0; m_serr = 1'b1; m_ovr = 1'b0;
      drive_bit(1'b0, 16 * 14);
      drive_bit(1'b1, 32);
      check_status("break");

      // Randomised frames.
      for (int n = 0; n < 25; n++) begin
         bdv = $urandom_range(0, 2);
         send_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11,
                    ($urandom_range(0, 4) == 0), bdv, 1'b0);
      end

      repeat (20) @(negedge clock);
      check("all_writes_seen", seen_writes, exp_writes);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
